hsv2rgb: RTL and testbench
==========================

// Module: hsv2rgb
// PURPOSE
//  Inverse of the colour-space front end: converts 8-bit hue/saturation/value
//  pixels back to 8-bit R/G/B for display overlay of tracked regions.
//  Fully pipelined, one pixel per clock, fixed latency, no dividers.
//  A sideband tag (e.g. pixel x/y) travels with each pixel, aligned to it.
// PARAMETERS
//  TAG_W     10   width of in_tag/out_tag sideband, >=1
//  LATENCY   5    localparam, number of register stages; not overridable
// PORTS
//  clock      in   1      system clock, all logic on posedge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      h/s/v/in_tag carry a pixel this cycle
//  h          in   8      hue, 0..255 = full circle, 43 codes per sector
//  s          in   8      saturation, 0..255
//  v          in   8      value, 0..255
//  in_tag     in   TAG_W  sideband, passed through unchanged
//  out_valid  out  1      r/g/b/out_tag hold a new pixel this cycle
//  r,g,b      out  8 each converted colour
//  out_tag    out  TAG_W  tag of the pixel on r/g/b
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous, active-high.
//  - Reset: all valid stages, out_valid, r, g, b, out_tag and all data regs = 0.
//    In-flight pixels are discarded. Reset has priority over in_valid.
//  - No backpressure: every stage advances every cycle. Throughput 1 pixel/clk.
//  - Latency: pixel sampled on edge k (in_valid=1) -> outputs and out_valid=1
//    registered on edge k+4. Output order matches input order; no bubbles
//    inserted or removed.
//  - Bubbles: a stage register loads data only when its valid bit is 1.
//    r/g/b/out_tag hold the last valid pixel while out_valid=0.
//  - S1: register h, s, v, in_tag, in_valid.
//  - S2: region = h/43 via constant compare chain
//    (0:0-42 1:43-85 2:86-128 3:129-171 4:172-214 5:215-255).
//    rem = (h - 43*region)*6, 8 bits, max 252, no overflow. Delay s, v, tag.
//  - S3: a = (s*rem)>>8; b = (s*(255-rem))>>8; p = (v*(255-s))>>8.
//    16-bit products; keep bits [15:8].
//  - S4: q = (v*(255-a))>>8; t = (v*(255-b))>>8. Delay p, region, v, tag.
//    Also delay flag z = (s==0).
//  - S5: if z then r=g=b=v exactly. Otherwise map by region:
//    0:(v,t,p) 1:(q,v,p) 2:(p,v,t) 3:(p,q,v) 4:(t,p,v) 5:(v,p,q).
//  - All arithmetic is unsigned truncation; no rounding.
//    The bench golden model uses the exact formulas above.
//  - Back-to-back valid pixels, isolated pixels and any valid pattern must
//    give bit-exact outputs with out_valid equal to in_valid delayed 4 edges.
//  - reset asserted mid-stream: out_valid=0 from the next edge until the first
//    post-reset pixel emerges 4 edges after its sampling edge.
// TESTING
//  - h=0,s=255,v=255 -> (255,0,0), out_valid exactly 4 edges after sampling.
//  - h=86,s=255,v=255 -> (0,255,0); h=172,s=255,v=255 -> (0,0,255).
//  - h=255,s=255,v=255 -> (255,0,15) (region 5, rem 240, q 15). Wrap boundary.
//  - s=0,v=100, h in {0,100,255} -> (100,100,100) each. v=0 -> (0,0,0).
//  - Stream 256 h values, s=200, v=180, back-to-back with random bubbles
//    -> bit-exact vs model; tags in order; outputs hold during bubbles.
//  - reset pulsed with 3 pixels in flight -> none emerge; out_valid=0 and
//    r/g/b=0. Next pixel appears 4 edges after sampling.

Source files
------------

// File: rtl/hsv2rgb_if.sv
// Pixel bus for the HSV-to-RGB converter: HSV pixels plus tag in, RGB pixels plus tag out.
// The master drives HSV pixels in; the slave (the converter) returns RGB.
interface hsv2rgb_if #(
    parameter int TAG_W = 10
) ();
    logic             in_valid;
    logic [7:0]       h;
    logic [7:0]       s;
    logic [7:0]       v;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic [7:0]       r;
    logic [7:0]       g;
    logic [7:0]       b;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, h, s, v, in_tag,
        input  out_valid, r, g, b, out_tag
    );

    modport slave (
        input  in_valid, h, s, v, in_tag,
        output out_valid, r, g, b, out_tag
    );
endinterface

// File: rtl/hsv2rgb.sv
// Five-stage HSV to RGB converter, one pixel per clock, output registered 4 edges
// after the sampling edge. Each stage holds its data through bubbles.
module hsv2rgb #(
    parameter int TAG_W = 10
) (
    input  logic       clock,
    input  logic       reset,
    hsv2rgb_if.slave   px
);
    localparam int LATENCY = 5;

    // vld bit i marks stage i+1 as holding a pixel; the last bit is out_valid
    logic [LATENCY-1:0] vld_q, vld_d;

    logic [7:0]       h1_q, h1_d, s1_q, s1_d, v1_q, v1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    logic [2:0]       region2_q, region2_d;
    logic [7:0]       rem2_q, rem2_d, s2_q, s2_d, v2_q, v2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;

    logic [7:0]       a3_q, a3_d, b3_q, b3_d, p3_q, p3_d, v3_q, v3_d;
    logic [2:0]       region3_q, region3_d;
    logic             z3_q, z3_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;

    logic [7:0]       q4_q, q4_d, t4_q, t4_d, p4_q, p4_d, v4_q, v4_d;
    logic [2:0]       region4_q, region4_d;
    logic             z4_q, z4_d;
    logic [TAG_W-1:0] tag4_q, tag4_d;

    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic [2:0]       region_s;
    logic [7:0]       base_s;
    logic [7:0]       diff_s;
    logic [15:0]      prod_a_s, prod_b_s, prod_p_s, prod_q_s, prod_t_s;

    // Next-state for every pipeline stage; each stage loads only behind a valid bit
    always_comb begin
        region_s = 3'd0;
        base_s   = 8'd0;
        diff_s   = 8'd0;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;

        vld_d = {vld_q[LATENCY-2:0], px.in_valid};

        h1_d   = px.in_valid ? px.h      : h1_q;
        s1_d   = px.in_valid ? px.s      : s1_q;
        v1_d   = px.in_valid ? px.v      : v1_q;
        tag1_d = px.in_valid ? px.in_tag : tag1_q;

        // Sector index from a constant compare chain instead of dividing by 43
        if (h1_q <= 8'd42) begin
            region_s = 3'd0; base_s = 8'd0;
        end else if (h1_q <= 8'd85) begin
            region_s = 3'd1; base_s = 8'd43;
        end else if (h1_q <= 8'd128) begin
            region_s = 3'd2; base_s = 8'd86;
        end else if (h1_q <= 8'd171) begin
            region_s = 3'd3; base_s = 8'd129;
        end else if (h1_q <= 8'd214) begin
            region_s = 3'd4; base_s = 8'd172;
        end else begin
            region_s = 3'd5; base_s = 8'd215;
        end
        diff_s = h1_q - base_s;

        region2_d = vld_q[0] ? region_s                                    : region2_q;
        rem2_d    = vld_q[0] ? 8'((diff_s << 2) + (diff_s << 1))          : rem2_q;
        s2_d      = vld_q[0] ? s1_q                                        : s2_q;
        v2_d      = vld_q[0] ? v1_q                                        : v2_q;
        tag2_d    = vld_q[0] ? tag1_q                                      : tag2_q;

        prod_a_s = {8'd0, s2_q} * {8'd0, rem2_q};
        prod_b_s = {8'd0, s2_q} * {8'd0, 8'd255 - rem2_q};
        prod_p_s = {8'd0, v2_q} * {8'd0, 8'd255 - s2_q};

        a3_d      = vld_q[1] ? prod_a_s[15:8]   : a3_q;
        b3_d      = vld_q[1] ? prod_b_s[15:8]   : b3_q;
        p3_d      = vld_q[1] ? prod_p_s[15:8]   : p3_q;
        v3_d      = vld_q[1] ? v2_q             : v3_q;
        region3_d = vld_q[1] ? region2_q        : region3_q;
        z3_d      = vld_q[1] ? (s2_q == 8'd0)   : z3_q;
        tag3_d    = vld_q[1] ? tag2_q           : tag3_q;

        prod_q_s = {8'd0, v3_q} * {8'd0, 8'd255 - a3_q};
        prod_t_s = {8'd0, v3_q} * {8'd0, 8'd255 - b3_q};

        q4_d      = vld_q[2] ? prod_q_s[15:8] : q4_q;
        t4_d      = vld_q[2] ? prod_t_s[15:8] : t4_q;
        p4_d      = vld_q[2] ? p3_q           : p4_q;
        v4_d      = vld_q[2] ? v3_q           : v4_q;
        region4_d = vld_q[2] ? region3_q      : region4_q;
        z4_d      = vld_q[2] ? z3_q           : z4_q;
        tag4_d    = vld_q[2] ? tag3_q         : tag4_q;

        out_tag_d = vld_q[3] ? tag4_q : out_tag_q;
        if (!vld_q[3]) begin
            r_d = r_q; g_d = g_q; b_d = b_q;
        end else if (z4_q) begin
            r_d = v4_q; g_d = v4_q; b_d = v4_q;
        end else begin
            case (region4_q)
                3'd0:    begin r_d = v4_q; g_d = t4_q; b_d = p4_q; end
                3'd1:    begin r_d = q4_q; g_d = v4_q; b_d = p4_q; end
                3'd2:    begin r_d = p4_q; g_d = v4_q; b_d = t4_q; end
                3'd3:    begin r_d = p4_q; g_d = q4_q; b_d = v4_q; end
                3'd4:    begin r_d = t4_q; g_d = p4_q; b_d = v4_q; end
                3'd5:    begin r_d = v4_q; g_d = p4_q; b_d = q4_q; end
                default: begin r_d = v4_q; g_d = v4_q; b_d = v4_q; end
            endcase
        end
    end

    // Stage registers; synchronous reset clears valids and all data
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q     <= '0;
            h1_q      <= 8'd0; s1_q <= 8'd0; v1_q <= 8'd0; tag1_q <= '0;
            region2_q <= 3'd0; rem2_q <= 8'd0; s2_q <= 8'd0; v2_q <= 8'd0; tag2_q <= '0;
            a3_q      <= 8'd0; b3_q <= 8'd0; p3_q <= 8'd0; v3_q <= 8'd0;
            region3_q <= 3'd0; z3_q <= 1'b0; tag3_q <= '0;
            q4_q      <= 8'd0; t4_q <= 8'd0; p4_q <= 8'd0; v4_q <= 8'd0;
            region4_q <= 3'd0; z4_q <= 1'b0; tag4_q <= '0;
            r_q       <= 8'd0; g_q <= 8'd0; b_q <= 8'd0; out_tag_q <= '0;
        end else begin
            vld_q     <= vld_d;
            h1_q      <= h1_d; s1_q <= s1_d; v1_q <= v1_d; tag1_q <= tag1_d;
            region2_q <= region2_d; rem2_q <= rem2_d; s2_q <= s2_d; v2_q <= v2_d; tag2_q <= tag2_d;
            a3_q      <= a3_d; b3_q <= b3_d; p3_q <= p3_d; v3_q <= v3_d;
            region3_q <= region3_d; z3_q <= z3_d; tag3_q <= tag3_d;
            q4_q      <= q4_d; t4_q <= t4_d; p4_q <= p4_d; v4_q <= v4_d;
            region4_q <= region4_d; z4_q <= z4_d; tag4_q <= tag4_d;
            r_q       <= r_d; g_q <= g_d; b_q <= b_d; out_tag_q <= out_tag_d;
        end
    end

    assign px.out_valid = vld_q[LATENCY-1];
    assign px.r         = r_q;
    assign px.g         = g_q;
    assign px.b         = b_q;
    assign px.out_tag   = out_tag_q;
endmodule

// File: tb/tb_hsv2rgb.sv
// Directed and randomized bench for hsv2rgb against an arithmetic HSV->RGB reference
// with a 4-edge expected-output pipeline.
module tb_hsv2rgb;
    localparam int TAG_W = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    hsv2rgb_if #(.TAG_W(TAG_W)) bus ();

    hsv2rgb #(.TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .px    (bus.slave)
    );

    always #5 clock = ~clock;

    // Expected pipeline: index k holds the pixel sampled k edges ago
    bit          pv   [5];
    logic [23:0] prgb [5];
    int          ptag [5];
    logic [23:0] last_rgb = 24'd0;
    int          last_tag = 0;

    function automatic logic [23:0] ref_rgb(input int hh, input int ss, input int vv);
        int region, rem, a, bb, p, q, t;
        region = hh / 43;
        rem    = (hh % 43) * 6;
        a      = (ss * rem) / 256;
        bb     = (ss * (255 - rem)) / 256;
        p      = (vv * (255 - ss)) / 256;
        q      = (vv * (255 - a)) / 256;
        t      = (vv * (255 - bb)) / 256;
        if (ss == 0) return {vv[7:0], vv[7:0], vv[7:0]};
        case (region)
            0:       return {vv[7:0], t[7:0],  p[7:0]};
            1:       return {q[7:0],  vv[7:0], p[7:0]};
            2:       return {p[7:0],  vv[7:0], t[7:0]};
            3:       return {p[7:0],  q[7:0],  vv[7:0]};
            4:       return {t[7:0],  p[7:0],  vv[7:0]};
            default: return {vv[7:0], p[7:0],  q[7:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit vld, input int hh, input int ss,
                        input int vv, input int tg);
        logic [TAG_W-1:0] tg_v;
        tg_v         = tg[TAG_W-1:0];
        reset        = rst;
        bus.in_valid = vld;
        bus.h        = hh[7:0];
        bus.s        = ss[7:0];
        bus.v        = vv[7:0];
        bus.in_tag   = tg_v;
        @(posedge clock);
        #1;
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                pv[i] = 1'b0; prgb[i] = 24'd0; ptag[i] = 0;
            end
            last_rgb = 24'd0;
            last_tag = 0;
        end else begin
            for (int i = 4; i > 0; i--) begin
                pv[i] = pv[i-1]; prgb[i] = prgb[i-1]; ptag[i] = ptag[i-1];
            end
            pv[0]   = vld;
            prgb[0] = ref_rgb(hh, ss, vv);
            ptag[0] = int'(tg_v);
        end
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, pv[4]});
        if (pv[4]) begin
            last_rgb = prgb[4];
            last_tag = ptag[4];
        end
        chk("rgb", {8'd0, bus.r, bus.g, bus.b}, {8'd0, last_rgb});
        chk("out_tag", 32'(bus.out_tag), 32'(last_tag));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.h = 8'd0; bus.s = 8'd0; bus.v = 8'd0; bus.in_tag = '0;
        for (int i = 0; i < 5; i++) begin
            pv[i] = 1'b0; prgb[i] = 24'd0; ptag[i] = 0;
        end

        step(1'b1, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 0);
        idle(2);

        // Primary and boundary hues, with explicit expected colours
        step(1'b0, 1'b1, 0, 255, 255, 11);
        idle(4);
        chk("h0_red", {8'd0, bus.r, bus.g, bus.b}, 32'h00FF0000);
        step(1'b0, 1'b1, 86, 255, 255, 12);
        idle(4);
        chk("h86_green", {8'd0, bus.r, bus.g, bus.b}, 32'h0000FF00);
        step(1'b0, 1'b1, 172, 255, 255, 13);
        idle(4);
        chk("h172_blue", {8'd0, bus.r, bus.g, bus.b}, 32'h000000FF);
        step(1'b0, 1'b1, 255, 255, 255, 14);
        idle(4);
        chk("h255_wrap", {8'd0, bus.r, bus.g, bus.b}, 32'h00FF000F);

        // Grey axis and black, back to back
        step(1'b0, 1'b1, 0, 0, 100, 21);
        step(1'b0, 1'b1, 100, 0, 100, 22);
        step(1'b0, 1'b1, 255, 0, 100, 23);
        step(1'b0, 1'b1, 77, 200, 0, 24);
        idle(3);
        chk("grey_h255", {8'd0, bus.r, bus.g, bus.b}, 32'h00646464);
        idle(1);
        chk("black", {8'd0, bus.r, bus.g, bus.b}, 32'h00000000);
        idle(2);

        // Full hue sweep with random bubbles and tags
        for (int hh = 0; hh < 256; hh++) begin
            while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 0, 0, 0, 0);
            step(1'b0, 1'b1, hh, 200, 180, int'($urandom_range(0, 1023)));
        end
        idle(5);

        // Fully random pixels and valid pattern
        for (int i = 0; i < 300; i++)
            step(1'b0, ($urandom_range(0, 2) != 0), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1023)));
        idle(5);

        // Reset with three pixels in flight; in_valid high during reset is ignored
        step(1'b0, 1'b1, 30, 255, 255, 31);
        step(1'b0, 1'b1, 60, 255, 255, 32);
        step(1'b0, 1'b1, 90, 255, 255, 33);
        step(1'b1, 1'b1, 120, 255, 255, 34);
        chk("rst_rgb_zero", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
        idle(5);
        step(1'b0, 1'b1, 200, 150, 220, 35);
        idle(3);
        chk("post_rst_not_yet", {31'd0, bus.out_valid}, 32'd0);
        idle(1);
        chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("post_rst_tag", 32'(bus.out_tag), 32'd35);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
